// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-type encodings and writeback-stage
// state encoding.
package mips_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a little-endian load word and
// sign- or zero-extends it; unlisted load types behave as LW.
module load_align
  import mips_pkg::*;
(
  input  logic [2:0]  ldtype,
  input  logic [1:0]  addrlo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addrlo, 3'b000} +: 8];
  // addrlo[0] is deliberately ignored for halfword accesses
  assign half_sel = addrlo[1] ? rdata[31:16] : rdata[15:0];

  // extend the selected lane according to the load type
  always_comb begin
    result = rdata;
    case (ldtype)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'h000000, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: accepts retiring instructions, waits for load data,
// and drives the register-file write port from registers.
module wb_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_regwen,
  input  logic [4:0]       in_waddr,
  input  logic [31:0]      in_alures,
  input  logic             in_isload,
  input  logic [2:0]       in_ldtype,
  input  logic [1:0]       in_addrlo,
  input  logic             dm_rvalid,
  input  logic [31:0]      dm_rdata,
  output logic             Regwen,
  output logic [4:0]       waddr,
  output logic [31:0]      wdata,
  output logic             load_pending,
  output logic [4:0]       pend_waddr,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err_spurious
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  wb_state_t   state;
  logic        lat_regwen;
  logic [4:0]  lat_waddr;
  logic [2:0]  lat_ldtype;
  logic [1:0]  lat_addrlo;
  logic [31:0] ld_result;

  load_align u_load_align (
    .ldtype (lat_ldtype),
    .addrlo (lat_addrlo),
    .rdata  (dm_rdata),
    .result (ld_result)
  );

  assign in_ready     = (state == WB_IDLE);
  assign load_pending = (state == WB_WAIT);
  assign pend_waddr   = (state == WB_WAIT) ? lat_waddr : 5'd0;

  // accept/retire FSM; write port, counter and error flag are all registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WB_IDLE;
      Regwen       <= 1'b0;
      waddr        <= 5'd0;
      wdata        <= 32'd0;
      retire_cnt   <= '0;
      err_spurious <= 1'b0;
      lat_regwen   <= 1'b0;
      lat_waddr    <= 5'd0;
      lat_ldtype   <= 3'b000;
      lat_addrlo   <= 2'b00;
    end else begin
      Regwen <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (dm_rvalid) begin
            err_spurious <= 1'b1;
          end
          if (in_valid) begin
            if (in_isload) begin
              lat_regwen <= in_regwen;
              lat_waddr  <= in_waddr;
              lat_ldtype <= in_ldtype;
              lat_addrlo <= in_addrlo;
              state      <= WB_WAIT;
            end else begin
              // register 0 retires and counts but never raises the write enable
              Regwen     <= in_regwen & (|in_waddr);
              waddr      <= in_waddr;
              wdata      <= in_alures;
              retire_cnt <= retire_cnt + CNT_ONE;
            end
          end
        end
        WB_WAIT: begin
          if (dm_rvalid) begin
            Regwen     <= lat_regwen & (|lat_waddr);
            waddr      <= lat_waddr;
            wdata      <= ld_result;
            retire_cnt <= retire_cnt + CNT_ONE;
            state      <= WB_IDLE;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the MIPS pipeline, sitting directly upstream of the general-purpose register file's write port. It accepts one retiring instruction per handshake from the memory stage and drives the register file's `Regwen`/`waddr`/`wdata` from registers. For loads it waits for the data-memory response and sign/zero-extends the addressed byte or halfword. It also exposes a load-pending indication for the hazard unit, a retired-instruction counter, and a sticky protocol-error flag.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_regwen`  in  1  instruction writes a register.
- `in_waddr`  in  5  destination register.
- `in_alures`  in  32  result for non-load instructions.
- `in_isload`  in  1  instruction is a load.
- `in_ldtype`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 treated as LW.
- `in_addrlo`  in  2  low two bits of the load address.
- `dm_rvalid`  in  1  data-memory read data valid (single-cycle pulse).
- `dm_rdata`  in  32  data-memory read data, little-endian.
- `Regwen`  out  1  register file write enable (registered).
- `waddr`  out  5  register file write address (registered).
- `wdata`  out  32  register file write data (registered).
- `load_pending`  out  1  a load is waiting for its data.
- `pend_waddr`  out  5  destination of the pending load; 0 when none is pending.
- `retire_cnt`  out  CNT_W  completed-instruction count; wraps modulo 2^CNT_W.
- `err_spurious`  out  1  sticky flag: `dm_rvalid` was seen with no load pending.

## Operation
- Two states: IDLE and WAIT. `in_ready` = (state == IDLE). `load_pending` = (state == WAIT).
- **IDLE with handshake, non-load:** register `Regwen` <= `in_regwen & |in_waddr`, `waddr` <= `in_waddr`, `wdata` <= `in_alures`. `retire_cnt` increments. Remain in IDLE.
- **IDLE with handshake, load:** latch `in_regwen`, `in_waddr`, `in_ldtype`, `in_addrlo`. Go to WAIT. `Regwen` <= 0.
- **IDLE without handshake:** `Regwen` <= 0. `waddr` and `wdata` hold their values.
- **WAIT with `dm_rvalid`:**
  - `Regwen` <= latched regwen & |latched waddr; `waddr` <= latched waddr; `wdata` <= extracted data.
  - `retire_cnt` increments. Go to IDLE.
- **WAIT without `dm_rvalid`:** `Regwen` <= 0. `in_valid` is ignored because `in_ready` = 0.
- **Extraction:**
  - Byte = `dm_rdata[8*addrlo +: 8]`; LB sign-extends, LBU zero-extends.
  - Halfword = `dm_rdata[16*addrlo[1] +: 16]`, with `addrlo[0]` ignored; LH sign-extends, LHU zero-extends.
  - LW passes `dm_rdata` unchanged and ignores `addrlo`.
- **Register 0:** a write to register 0 never asserts `Regwen`, but it still retires and counts.
- **Spurious response:** `dm_rvalid` in IDLE sets `err_spurious`, which stays set until `rst`. No write occurs and the counter does not change.
- **Counter wrap:** `retire_cnt` wraps from all-ones to 0.

## Timing
- **Reset values:** state IDLE; `Regwen`=0, `waddr`=0, `wdata`=0, `retire_cnt`=0, `err_spurious`=0, `load_pending`=0, `pend_waddr`=0, `in_ready`=1 in the cycle after reset.
- `rst` dominates every other input in the same cycle.
- **Reset mid-WAIT:** the pending load is abandoned with no write. A late `dm_rvalid` arriving after reset sets `err_spurious`.
- **Non-load latency:**
  - Handshake sampled at edge N.
  - `Regwen`/`waddr`/`wdata` valid for exactly the cycle after edge N.
  - Register file updated at edge N+1.
- **Load latency:** `Regwen` is high for exactly the one cycle following the edge that samples `dm_rvalid`.
- **Back-to-back:** non-loads sustain one per cycle. A load blocks acceptance from the edge that accepts it through the edge that samples `dm_rvalid`, inclusive.
- **Same-edge events:** a new instruction cannot be accepted on the edge that samples `dm_rvalid`, because `in_ready` is 0 in WAIT. The earliest next acceptance is the following edge.
- **Write pulse width:** `Regwen` is never high for two consecutive cycles from a single instruction.

## Structure
- **Shared package `mips_pkg`:**
  - Load-type constants LB/LH/LW/LBU/LHU.
  - `wb_state` encoding (IDLE=0, WAIT=1).
- **Sub-module `load_align`:** purely combinational. Inputs: `ldtype`, `addrlo`, `rdata`. Output: the extended 32-bit result. `wb_stage` instantiates it once.

## Test plan
- **Reset, then non-load:** `in_waddr`=8, `in_alures`=0x12345678 -> `Regwen`=1, `waddr`=8, `wdata`=0x12345678 for one cycle; `retire_cnt`=1.
- **Byte loads:** LB with `addrlo`=3, `dm_rdata`=0x80FF0000 -> `wdata`=0xFFFFFF80. LBU with the same data -> 0x00000080.
- **Halfword loads:**
  - LH with `addrlo`=2, `dm_rdata`=0x8001_1234 -> `wdata`=0xFFFF8001.
  - LHU with `addrlo`=0 on the same data -> 0x00001234.
  - `dm_rvalid` delayed 5 cycles: `in_ready`=0, `load_pending`=1, `pend_waddr` correct throughout the wait.
- **Register 0 and spurious response:** write to `waddr`=0 -> `Regwen` stays 0 and `retire_cnt` still increments. `dm_rvalid` pulse in IDLE -> `err_spurious`=1, held until `rst`.
- **Reset during WAIT:** `rst` asserted while waiting, then `dm_rvalid` -> no write, `err_spurious`=1. With `CNT_W`=4, 16 retirements -> `retire_cnt`=0.
